// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter-width helper for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter must hold values 0..WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder, the addition twin of the diff/borr subtractor cell
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ cin_i;
    assign co_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder built from one full-adder cell and a carry flop
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;

    full_adder_bit u_fa (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .co_o  (fa_co)
    );

    // Next-state and datapath: capture on accepted start, one bit per cycle in RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cout_d  = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset abandons any sum in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table, corner sequences and random ops checked against plain a+b+cin
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    int n_chk = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge: present operands with start high
    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a = va;
        b = vb;
        cin = vc;
        start = 1'b1;
    endtask

    // Wait for done, checking latency, busy length and result; optional stray start at glitch_at
    task automatic finish_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                             input string nm, input int glitch_at);
        logic [8:0] ref_v;
        int lat = 0;
        int busy_n = 0;
        ref_v = 9'(va) + 9'(vb) + 9'(vc);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (glitch_at != 0 && i == glitch_at) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
                cin = 1'b1;
            end
            if (glitch_at != 0 && i == glitch_at + 1) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd9);
        chk({nm, " busy_cycles"}, 32'(busy_n), 32'd8);
        chk({nm, " sum"}, 32'(sum), 32'(ref_v[7:0]));
        chk({nm, " cout"}, 32'(cout), 32'(ref_v[8]));
    endtask

    initial begin
        vec_t v[5];
        int done_seen;
        v[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        v[1] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        v[2] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        v[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        v[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset sum", 32'(sum), 0);
        chk("reset cout", 32'(cout), 0);
        rst_n = 1'b1;

        // Directed table; expected values also cross-checked by the model inside finish_op
        for (int i = 0; i < 5; i++) begin
            launch(v[i].a, v[i].b, v[i].cin);
            finish_op(v[i].a, v[i].b, v[i].cin, $sformatf("vec%0d", i), 0);
            chk($sformatf("vec%0d table_sum", i), 32'(sum), 32'(v[i].s));
            chk($sformatf("vec%0d table_cout", i), 32'(cout), 32'(v[i].co));
            @(negedge clk);
            chk($sformatf("vec%0d done_one_cycle", i), 32'(done), 0);
            chk($sformatf("vec%0d sum_held", i), 32'(sum), 32'(v[i].s));
        end

        // Start while busy is ignored
        launch(8'h12, 8'h34, 1'b0);
        finish_op(8'h12, 8'h34, 1'b0, "ignored_start", 3);
        chk("ignored_start sum_46", 32'(sum), 32'h46);
        @(negedge clk);

        // Reset mid-RUN abandons the op
        launch(8'h33, 8'h44, 1'b1);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("midrun busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrun busy", 32'(busy), 0);
        chk("midrun done", 32'(done), 0);
        chk("midrun sum", 32'(sum), 0);
        chk("midrun cout", 32'(cout), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("midrun no_done", 32'(done_seen), 0);
        launch(8'h80, 8'h80, 1'b0);
        finish_op(8'h80, 8'h80, 1'b0, "after_reset", 0);

        // Back-to-back: start held on the done cycle
        launch(8'h01, 8'h02, 1'b0);
        finish_op(8'h01, 8'h02, 1'b0, "b2b_first", 0);
        launch(8'h01, 8'h02, 1'b0);
        finish_op(8'h01, 8'h02, 1'b0, "b2b_second", 0);
        chk("b2b sum_03", 32'(sum), 32'h03);

        // Random ops, sometimes chained straight off the done cycle
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(1) == 0) @(negedge clk);
            launch(ra, rb, rc);
            finish_op(ra, rb, rc, $sformatf("rand%0d", k), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
